alu_sequencer: RTL

//  Multi-cycle control unit that executes one 10-bit instruction at a time on the shared
//  bus / register file / ALU datapath. Decodes {FN,RX,RY} and sequences the ALU

---
 rtl/alu_ctrl_pkg.sv | 53 +++++
 rtl/reg_sel_decoder.sv | 27 ++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared types and constants for the ALU sequencer. Holds the
//                opcode and state enums, the instruction field positions and
//                a helper that classifies ALU opcodes.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam int FN_W   = 4;
    localparam int RSEL_W = 3;
    localparam int NREG   = 1 << RSEL_W;
    localparam int INST_W = FN_W + 2 * RSEL_W;

    // Instruction layout {FN, RX, RY}
    localparam int FN_MSB = INST_W - 1;
    localparam int FN_LSB = 2 * RSEL_W;
    localparam int RX_MSB = 2 * RSEL_W - 1;
    localparam int RX_LSB = RSEL_W;
    localparam int RY_MSB = RSEL_W - 1;
    localparam int RY_LSB = 0;

    typedef enum logic [FN_W-1:0] {
        OP_LD  = 4'd0,
        OP_MOV = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_INV = 4'd7,
        OP_FLP = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10,
        OP_ASR = 4'd11
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4
    } state_t;

    // Opcodes that run the four-step A/B/Q/writeback sequence
    function automatic logic is_alu_op(input logic [FN_W-1:0] fn);
        return (fn >= OP_ADD) && (fn <= OP_ASR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_sel_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : reg_sel_decoder
//  Description : Binary register select to one-hot enable vector, gated by an
//                enable. All outputs are zero while the enable is low.
//  Ports       : i_sel    binary register index
//                i_en     enable; output is all-zero when low
//                o_onehot one-hot select (2**SEL_W bits)
//  Revision    : 1.0  initial release
// ============================================================================
module reg_sel_decoder #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      i_sel,
    input  logic                  i_en,
    output logic [(1<<SEL_W)-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle control unit for the shared bus / register file /
//                ALU datapath. Executes one {FN,RX,RY} instruction at a time
//                and produces Moore-decoded datapath enables. All state
//                changes on the falling edge of CLKb.
//  Ports       : CLKb    clock (falling-edge active)
//                RST     asynchronous active-high reset
//                INSTR   instruction, captured when Exec is accepted in IDLE
//                Exec    start request
//                Ready   idle indicator
//                Done    final state of an instruction
//                Illegal T1 of an unsupported opcode
//                FN      ALU function (0 when idle)
//                Ain/Gin/Gout  ALU A load / B load / compute enables
//                ALUout/ExtOut ALU result / external data bus drivers
//                Rout/Rin      one-hot register bus-drive / load enables
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer
    import alu_ctrl_pkg::*;
(
    input  logic              CLKb,
    input  logic              RST,
    input  logic [INST_W-1:0] INSTR,
    input  logic              Exec,
    output logic              Ready,
    output logic              Done,
    output logic              Illegal,
    output logic [FN_W-1:0]   FN,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              ALUout,
    output logic              ExtOut,
    output logic [NREG-1:0]   Rout,
    output logic [NREG-1:0]   Rin
);

    state_t              r_state;
    state_t              w_next;
    logic [INST_W-1:0]   r_ir;

    logic [FN_W-1:0]     w_fn;
    logic [RSEL_W-1:0]   w_rx;
    logic [RSEL_W-1:0]   w_ry;
    logic                w_rin_en;
    logic                w_rout_en;
    logic                w_rout_ry;
    logic [RSEL_W-1:0]   w_rout_sel;

    assign w_fn = r_ir[FN_MSB:FN_LSB];
    assign w_rx = r_ir[RX_MSB:RX_LSB];
    assign w_ry = r_ir[RY_MSB:RY_LSB];

    always_ff @(negedge CLKb or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            // IR only loads on acceptance, so INSTR is free to change while busy
            if ((r_state == S_IDLE) && Exec) begin
                r_ir <= INSTR;
            end
        end
    end

    always_comb begin
        w_next    = S_IDLE;
        Ready     = 1'b0;
        Done      = 1'b0;
        Illegal   = 1'b0;
        FN        = '0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        Gout      = 1'b0;
        ALUout    = 1'b0;
        ExtOut    = 1'b0;
        w_rin_en  = 1'b0;
        w_rout_en = 1'b0;
        w_rout_ry = 1'b0;
        case (r_state)
            S_IDLE: begin
                Ready  = 1'b1;
                w_next = Exec ? S_T1 : S_IDLE;
            end
            S_T1: begin
                FN = w_fn;
                if (w_fn == OP_LD) begin
                    ExtOut   = 1'b1;
                    w_rin_en = 1'b1;
                    Done     = 1'b1;
                end else if (w_fn == OP_MOV) begin
                    w_rout_en = 1'b1;
                    w_rout_ry = 1'b1;
                    w_rin_en  = 1'b1;
                    Done      = 1'b1;
                end else if (is_alu_op(w_fn)) begin
                    w_rout_en = 1'b1;
                    Ain       = 1'b1;
                    w_next    = S_T2;
                end else begin
                    Illegal = 1'b1;
                    Done    = 1'b1;
                end
            end
            S_T2: begin
                FN        = w_fn;
                w_rout_en = 1'b1;
                w_rout_ry = 1'b1;
                Gin       = 1'b1;
                w_next    = S_T3;
            end
            S_T3: begin
                FN     = w_fn;
                Gout   = 1'b1;
                w_next = S_T4;
            end
            S_T4: begin
                FN       = w_fn;
                ALUout   = 1'b1;
                w_rin_en = 1'b1;
                Done     = 1'b1;
            end
            // Unused encodings drive nothing and fall back to IDLE
            default: w_next = S_IDLE;
        endcase
    end

    assign w_rout_sel = w_rout_ry ? w_ry : w_rx;

    reg_sel_decoder #(.SEL_W(RSEL_W)) u_rin_dec (
        .i_sel    (w_rx),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

    reg_sel_decoder #(.SEL_W(RSEL_W)) u_rout_dec (
        .i_sel    (w_rout_sel),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

endmodule
`default_nettype wire
